// File: rtl/bram_boot_loader_if.sv
// Byte-stream, AHB-side and BRAM-side signals of the boot loader, bundled with
// master (environment) and slave (loader) views.
interface bram_boot_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] ahb_bram_addr;
  logic [31:0]           ahb_bram_wdata;
  logic [3:0]            ahb_bram_write;
  logic [ADDR_WIDTH-1:0] BRAM_ADDR;
  logic [31:0]           BRAM_WDATA;
  logic [3:0]            BRAM_WRITE;

  modport master (
    output rx_valid, rx_data, ahb_bram_addr, ahb_bram_wdata, ahb_bram_write,
    input  rx_ready, BRAM_ADDR, BRAM_WDATA, BRAM_WRITE
  );

  modport slave (
    input  rx_valid, rx_data, ahb_bram_addr, ahb_bram_wdata, ahb_bram_write,
    output rx_ready, BRAM_ADDR, BRAM_WDATA, BRAM_WRITE
  );
endinterface

// File: rtl/bram_boot_loader.sv
// Boot sequencer: receives a framed image byte stream, writes it into BRAM,
// verifies the XOR checksum, then hands the BRAM port to AHB and releases the CPU.
//
// state  | meaning
// IDLE   | hunting for 0xA5 magic, other bytes dropped
// LEN0   | expecting LEN[7:0]
// LEN1   | expecting LEN[15:8], range check
// DATA   | assembling words, one BRAM write per 4 bytes
// CSUM   | expecting checksum byte
// DONE   | image loaded, BRAM owned by AHB, terminal until reset
module bram_boot_loader #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  bram_boot_loader_if.slave      bus,
  output logic                   cpu_reset_n,
  output logic                   load_done,
  output logic                   load_err
);
  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  rx_ready_q, rx_ready_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            acc_q, acc_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_q, cpu_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic                  abort;
  logic [15:0]           len_full;

  assign accept = bus.rx_valid & rx_ready_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    word_d   = word_q;
    acc_d    = acc_q;
    tmo_d    = tmo_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    abort    = 1'b0;
    len_full = {bus.rx_data, len_q[7:0]};

    case (state_q)
      S_IDLE: if (accept && bus.rx_data == 8'hA5) begin
        state_d = S_LEN0;
        err_d   = 1'b0;
        idx_d   = '0;
        acc_d   = '0;
        bcnt_d  = '0;
      end
      S_LEN0: if (accept) begin
        len_d[7:0] = bus.rx_data;
        state_d    = S_LEN1;
      end
      S_LEN1: if (accept) begin
        len_d = len_full;
        if ({1'b0, len_full} > MAX_LEN) abort = 1'b1;
        else if (len_full == 16'd0)     state_d = S_CSUM;
        else                            state_d = S_DATA;
      end
      S_DATA: if (accept) begin
        word_d = {bus.rx_data, word_q[23:8]};
        acc_d  = acc_q ^ bus.rx_data;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          wdata_d = {bus.rx_data, word_q};
          idx_d   = idx_q + 1'b1;
          if (17'(idx_q) + 17'd1 == {1'b0, len_q}) state_d = S_CSUM;
        end
      end
      S_CSUM: if (accept) begin
        if (bus.rx_data == acc_q) state_d = S_DONE;
        else                      abort   = 1'b1;
      end
      default: ;
    endcase

    // Inter-byte watchdog: down-counter reloaded by every accepted byte.
    if (accept) begin
      tmo_d = TW'(TIMEOUT_CYCLES);
    end else if (state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM}) begin
      if (tmo_q <= TW'(1)) abort = 1'b1;
      else                 tmo_d = tmo_q - TW'(1);
    end

    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end

    rx_ready_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    cpu_d      = (state_q == S_DONE);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= rx_ready_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      acc_q      <= acc_d;
      tmo_q      <= tmo_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_q      <= cpu_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Once loaded, AHB drives the BRAM port directly with no added latency.
  assign bus.rx_ready   = rx_ready_q;
  assign bus.BRAM_ADDR  = (state_q == S_DONE) ? bus.ahb_bram_addr  : addr_q;
  assign bus.BRAM_WDATA = (state_q == S_DONE) ? bus.ahb_bram_wdata : wdata_q;
  assign bus.BRAM_WRITE = (state_q == S_DONE) ? bus.ahb_bram_write : {4{we_q}};
  assign cpu_reset_n    = cpu_q;
  assign load_done      = done_q;
  assign load_err       = err_q;
endmodule

// File: tb/tb_bram_boot_loader.sv
// Directed bench for bram_boot_loader: frame table plus hand sequences for
// strobe timing, timeout, LEN boundary, mid-frame reset and AHB passthrough.
module tb_bram_boot_loader;
  localparam int AW = 4;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic cpu_reset_n, load_done, load_err;

  bram_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

  bram_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .bus         (bus.slave),
    .cpu_reset_n (cpu_reset_n),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [31:0] shadow [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Loader-side writes are captured mid-cycle; every strobe must be a full word.
  always @(negedge HCLK) begin
    if (HRESETn && !load_done && bus.BRAM_WRITE != 4'h0) begin
      wr_cnt++;
      chk("strobe_full_word", {28'd0, bus.BRAM_WRITE}, 32'hF);
      shadow[bus.BRAM_ADDR] = bus.BRAM_WDATA;
    end
  end

  task automatic do_reset();
    HRESETn = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    wr_cnt = 0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    @(posedge HCLK);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  typedef struct {
    string        name;
    logic [127:0] frame;
    int           n;
    int           exp_wr;
    logic         exp_done;
    logic         exp_err;
    logic [31:0]  exp_m0;
    logic [31:0]  exp_m1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.ahb_bram_addr = '0;
    bus.ahb_bram_wdata = 32'h0;
    bus.ahb_bram_write = 4'h0;

    vecs[0] = '{"good2", 128'hA5020044332211EFBEADDE66, 12, 2, 1'b1, 1'b0, 32'h11223344, 32'hDEADBEEF};
    vecs[1] = '{"badcsum", 128'hA5020044332211EFBEADDE67, 12, 2, 1'b0, 1'b1, 32'h11223344, 32'hDEADBEEF};
    vecs[2] = '{"stray_len0", 128'h00FF12A5000000, 7, 0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{"len17", 128'hA51100, 3, 0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[4] = '{"len0_badcsum", 128'hA5000001, 4, 0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{"one_word_bad", 128'hA501000102030405, 8, 1, 1'b0, 1'b1, 32'h04030201, 32'h0};

    // Reset values while reset is held
    #2;
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("rst_write", {28'd0, bus.BRAM_WRITE}, 32'd0);
    chk("rst_addr", {28'd0, bus.BRAM_ADDR}, 32'd0);
    chk("rst_wdata", bus.BRAM_WDATA, 32'd0);
    chk("rst_cpu", {31'd0, cpu_reset_n}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    do_reset();
    chk("rx_ready_after_rst", {31'd0, bus.rx_ready}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(vecs[v].frame[8*(vecs[v].n-1-i) +: 8]);
      tick(2);
      chk({vecs[v].name, "_writes"}, wr_cnt, vecs[v].exp_wr);
      chk({vecs[v].name, "_done"}, {31'd0, load_done}, {31'd0, vecs[v].exp_done});
      chk({vecs[v].name, "_err"}, {31'd0, load_err}, {31'd0, vecs[v].exp_err});
      chk({vecs[v].name, "_cpu"}, {31'd0, cpu_reset_n}, {31'd0, vecs[v].exp_done});
      chk({vecs[v].name, "_rx_ready"}, {31'd0, bus.rx_ready}, {31'd0, !vecs[v].exp_done});
      chk({vecs[v].name, "_mem0"}, shadow[0], vecs[v].exp_m0);
      chk({vecs[v].name, "_mem1"}, shadow[1], vecs[v].exp_m1);
    end

    // Strobe timing, cpu release latency, DONE lock-out and AHB passthrough
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    chk("t_strobe_on", {28'd0, bus.BRAM_WRITE}, 32'hF);
    chk("t_addr0", {28'd0, bus.BRAM_ADDR}, 32'd0);
    chk("t_wdata0", bus.BRAM_WDATA, 32'h11223344);
    send_byte(8'hEF);
    chk("t_strobe_off", {28'd0, bus.BRAM_WRITE}, 32'h0);
    send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    chk("t_addr1", {28'd0, bus.BRAM_ADDR}, 32'd1);
    chk("t_wdata1", bus.BRAM_WDATA, 32'hDEADBEEF);
    send_byte(8'h66);
    chk("t_done", {31'd0, load_done}, 32'd1);
    chk("t_cpu_still_low", {31'd0, cpu_reset_n}, 32'd0);
    chk("t_rx_ready_low", {31'd0, bus.rx_ready}, 32'd0);
    tick(1);
    chk("t_cpu_release", {31'd0, cpu_reset_n}, 32'd1);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'hA5;
    tick(3);
    bus.rx_valid = 1'b0;
    chk("t_done_sticky", {31'd0, load_done}, 32'd1);
    chk("t_err_clear", {31'd0, load_err}, 32'd0);
    bus.ahb_bram_addr = 4'd5;
    bus.ahb_bram_wdata = 32'hCAFEF00D;
    bus.ahb_bram_write = 4'h3;
    #1;
    chk("ahb_addr", {28'd0, bus.BRAM_ADDR}, 32'd5);
    chk("ahb_wdata", bus.BRAM_WDATA, 32'hCAFEF00D);
    chk("ahb_write", {28'd0, bus.BRAM_WRITE}, 32'h3);
    bus.ahb_bram_write = 4'h0;
    tick(1);

    // Bad frame then good frame without reset: error clears on magic
    do_reset();
    for (int i = 0; i < 12; i++) send_byte(vecs[1].frame[8*(11-i) +: 8]);
    chk("rec_err_set", {31'd0, load_err}, 32'd1);
    send_byte(8'hA5);
    chk("rec_err_clear", {31'd0, load_err}, 32'd0);
    for (int i = 1; i < 12; i++) send_byte(vecs[0].frame[8*(11-i) +: 8]);
    tick(1);
    chk("rec_done", {31'd0, load_done}, 32'd1);
    chk("rec_cpu", {31'd0, cpu_reset_n}, 32'd1);
    chk("rec_writes", wr_cnt, 32'd4);

    // Timeout boundary: 15 idle cycles tolerated, 16th aborts
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h44);
    tick(15);
    chk("tmo_not_yet", {31'd0, load_err}, 32'd0);
    tick(1);
    chk("tmo_abort", {31'd0, load_err}, 32'd1);
    send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    chk("tmo_idle_drops", {31'd0, load_done}, 32'd0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    tick(1);
    chk("tmo_then_load", {31'd0, load_done}, 32'd1);
    chk("tmo_writes", wr_cnt, 32'd0);

    // LEN == depth is the largest legal image
    do_reset();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    send_byte(8'h00);
    tick(1);
    chk("full_done", {31'd0, load_done}, 32'd1);
    chk("full_writes", wr_cnt, 32'd16);
    chk("full_first", shadow[0], 32'h03020100);
    chk("full_last", shadow[15], 32'h3F3E3D3C);

    // Reset after the 3rd data byte with the 4th on the bus
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h11;
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("mid_rst_write", {28'd0, bus.BRAM_WRITE}, 32'd0);
    tick(1);
    chk("mid_rst_no_write", wr_cnt, 32'd0);
    chk("mid_rst_addr", {28'd0, bus.BRAM_ADDR}, 32'd0);
    chk("mid_rst_wdata", bus.BRAM_WDATA, 32'd0);
    chk("mid_rst_cpu", {31'd0, cpu_reset_n}, 32'd0);
    chk("mid_rst_done", {31'd0, load_done}, 32'd0);
    bus.rx_valid = 1'b0;
    HRESETn = 1'b1;
    tick(1);
    send_byte(8'h11);
    tick(1);
    chk("mid_rst_idle", wr_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
